// File: rtl/mux_arb_pkg.sv
// Shared definitions for the round-robin mux arbiter: state encoding and a
// ceiling-log2 helper used to size the priority pointer.
package mux_arb_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_e;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

endpackage

// File: rtl/mux_onehot.sv
// N:1 one-hot AND-OR multiplexer; the output is zero when no select bit is set.
module mux_onehot #(
    parameter int N = 4,
    parameter int W = 8
) (
    input  logic [N-1:0]   sel_i,
    input  logic [N*W-1:0] data_i,
    output logic [W-1:0]   data_o
);

    always_comb begin
        data_o = '0;
        for (int i = 0; i < N; i++) begin
            if (sel_i[i]) data_o = data_o | data_i[i*W +: W];
        end
    end

endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter that owns the select of an N:1 valid/ready mux, holding
// the grant for a whole burst and rotating priority after each last beat.
module mux_rr_arbiter
    import mux_arb_pkg::*;
#(
    parameter int N = 4,
    parameter int W = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   in_valid,
    input  logic [N*W-1:0] in_data,
    input  logic [N-1:0]   in_last,
    output logic [N-1:0]   in_ready,
    output logic           out_valid,
    output logic [W-1:0]   out_data,
    output logic           out_last,
    input  logic           out_ready,
    output logic [N-1:0]   grant,
    output logic           busy
);

    localparam int PW = (clog2(N) < 1) ? 1 : clog2(N);

    state_e        state_q, state_d;
    logic [PW-1:0] ptr_q, ptr_d;
    logic [PW-1:0] gidx_q, gidx_d;
    logic [N-1:0]  grant_q, grant_d;

    logic [N-1:0]  rot;
    logic [PW-1:0] off;
    logic [PW:0]   sum_w;
    logic [PW-1:0] pick;
    logic [N-1:0]  pick_oh;
    logic          xfer_last;

    // Rotate requests so bit 0 is the current priority holder, find the
    // lowest set bit, then rotate the index back into requester space.
    always_comb begin
        rot   = N'({in_valid, in_valid} >> ptr_q);
        off   = '0;
        for (int j = N - 1; j >= 0; j--) begin
            if (rot[j]) off = PW'(j);
        end
        sum_w = {1'b0, ptr_q} + {1'b0, off};
        if (sum_w >= (PW+1)'(N)) sum_w = sum_w - (PW+1)'(N);
        pick    = sum_w[PW-1:0];
        pick_oh = {{(N-1){1'b0}}, 1'b1} << pick;
    end

    mux_onehot #(.N(N), .W(W)) u_mux_data (
        .sel_i  (grant_q),
        .data_i (in_data),
        .data_o (out_data)
    );

    mux_onehot #(.N(N), .W(1)) u_mux_valid (
        .sel_i  (grant_q),
        .data_i (in_valid),
        .data_o (out_valid)
    );

    mux_onehot #(.N(N), .W(1)) u_mux_last (
        .sel_i  (grant_q),
        .data_i (in_last),
        .data_o (out_last)
    );

    assign in_ready  = grant_q & {N{out_ready}};
    assign grant     = grant_q;
    assign busy      = (state_q == ST_GRANT);
    assign xfer_last = out_valid & out_ready & out_last;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        gidx_d  = gidx_q;
        grant_d = grant_q;
        case (state_q)
            ST_IDLE: begin
                if (|in_valid) begin
                    state_d = ST_GRANT;
                    grant_d = pick_oh;
                    gidx_d  = pick;
                end
            end
            ST_GRANT: begin
                if (xfer_last) begin
                    state_d = ST_IDLE;
                    grant_d = '0;
                    ptr_d   = (gidx_q == PW'(N - 1)) ? '0 : gidx_q + PW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            gidx_q  <= '0;
            grant_q <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gidx_q  <= gidx_d;
            grant_q <= grant_d;
        end
    end

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Directed table-driven bench for mux_rr_arbiter (N=4, W=8): each record is one
// clock cycle of inputs plus the outputs expected before the next rising edge.
module tb_mux_rr_arbiter;

    localparam int N = 4;
    localparam int W = 8;

    logic           clk;
    logic           rst;
    logic [N-1:0]   in_valid;
    logic [N*W-1:0] in_data;
    logic [N-1:0]   in_last;
    logic [N-1:0]   in_ready;
    logic           out_valid;
    logic [W-1:0]   out_data;
    logic           out_last;
    logic           out_ready;
    logic [N-1:0]   grant;
    logic           busy;

    mux_rr_arbiter #(.N(N), .W(W)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_ready (out_ready),
        .grant     (grant),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic [3:0]  v;
        logic [3:0]  l;
        logic [31:0] d;
        logic        o;
        logic [3:0]  g;
        logic        b;
        logic        ov;
        logic [7:0]  od;
        logic        ol;
        logic [3:0]  ir;
        logic [1:0]  p;
    } vec_t;

    vec_t tbl[$];
    int   total;
    int   bad;
    int   bp_beats;

    task automatic chk(input string nm, input int cyc, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cycle %0d: got %h expected %h", nm, cyc, act, exp);
        end
    endtask

    task automatic add(input logic r, input logic [3:0] v, input logic [3:0] l, input logic [31:0] d,
                       input logic o, input logic [3:0] g, input logic b, input logic ov,
                       input logic [7:0] od, input logic ol, input logic [3:0] ir, input logic [1:0] p);
        vec_t e;
        e.rst = r; e.v = v; e.l = l; e.d = d; e.o = o;
        e.g = g; e.b = b; e.ov = ov; e.od = od; e.ol = ol; e.ir = ir; e.p = p;
        tbl.push_back(e);
    endtask

    // Drive one cycle, compare the combinational view, then advance past the edge.
    task automatic run_vec(input vec_t e, input int cyc);
        rst       = e.rst;
        in_valid  = e.v;
        in_last   = e.l;
        in_data   = e.d;
        out_ready = e.o;
        #2;
        chk("grant",     cyc, 32'(grant),      32'(e.g));
        chk("busy",      cyc, 32'(busy),       32'(e.b));
        chk("out_valid", cyc, 32'(out_valid),  32'(e.ov));
        chk("out_data",  cyc, 32'(out_data),   32'(e.od));
        chk("out_last",  cyc, 32'(out_last),   32'(e.ol));
        chk("in_ready",  cyc, 32'(in_ready),   32'(e.ir));
        chk("ptr",       cyc, 32'(u_dut.ptr_q), 32'(e.p));
        if (out_valid && out_ready && grant == 4'b0010 && out_data[7:4] == 4'hA) bp_beats++;
        @(posedge clk);
        #1;
    endtask

    localparam logic [31:0] DF = 32'h44332211;

    initial begin
        vec_t e;
        total    = 0;
        bad      = 0;
        bp_beats = 0;
        rst       = 1'b1;
        in_valid  = '1;
        in_last   = '1;
        in_data   = DF;
        out_ready = 1'b1;
        @(posedge clk);
        #1;

        // reset with all requesters valid, then first grant goes to requester 0
        add(1, 4'hF, 4'hF, DF, 1, 4'h0, 0, 0, 8'h00, 0, 4'h0, 2'd0);
        add(0, 4'hF, 4'hF, DF, 1, 4'h0, 0, 0, 8'h00, 0, 4'h0, 2'd0);
        add(0, 4'hF, 4'hF, DF, 1, 4'h1, 1, 1, 8'h11, 1, 4'h1, 2'd0);
        add(0, 4'h0, 4'h0, 0,  1, 4'h0, 0, 0, 8'h00, 0, 4'h0, 2'd1);
        // requester 2 three-beat burst
        add(0, 4'h4, 4'h0, 32'h00110000, 1, 4'h0, 0, 0, 8'h00, 0, 4'h0, 2'd1);
        add(0, 4'h4, 4'h0, 32'h00110000, 1, 4'h4, 1, 1, 8'h11, 0, 4'h4, 2'd1);
        add(0, 4'h4, 4'h0, 32'h00220000, 1, 4'h4, 1, 1, 8'h22, 0, 4'h4, 2'd1);
        add(0, 4'h4, 4'h4, 32'h00330000, 1, 4'h4, 1, 1, 8'h33, 1, 4'h4, 2'd1);
        add(0, 4'h0, 4'h0, 0,            1, 4'h0, 0, 0, 8'h00, 0, 4'h0, 2'd3);
        // requester 3 single beat wraps ptr to 0
        add(0, 4'h8, 4'h8, 32'h99000000, 1, 4'h0, 0, 0, 8'h00, 0, 4'h0, 2'd3);
        add(0, 4'h8, 4'h8, 32'h99000000, 1, 4'h8, 1, 1, 8'h99, 1, 4'h8, 2'd3);
        // fairness: all requesters, single-beat bursts
        add(0, 4'hF, 4'hF, DF, 1, 4'h0, 0, 0, 8'h00, 0, 4'h0, 2'd0);
        add(0, 4'hF, 4'hF, DF, 1, 4'h1, 1, 1, 8'h11, 1, 4'h1, 2'd0);
        add(0, 4'hF, 4'hF, DF, 1, 4'h0, 0, 0, 8'h00, 0, 4'h0, 2'd1);
        add(0, 4'hF, 4'hF, DF, 1, 4'h2, 1, 1, 8'h22, 1, 4'h2, 2'd1);
        add(0, 4'hF, 4'hF, DF, 1, 4'h0, 0, 0, 8'h00, 0, 4'h0, 2'd2);
        add(0, 4'hF, 4'hF, DF, 1, 4'h4, 1, 1, 8'h33, 1, 4'h4, 2'd2);
        add(0, 4'hF, 4'hF, DF, 1, 4'h0, 0, 0, 8'h00, 0, 4'h0, 2'd3);
        add(0, 4'hF, 4'hF, DF, 1, 4'h8, 1, 1, 8'h44, 1, 4'h8, 2'd3);
        add(0, 4'hF, 4'hF, DF, 1, 4'h0, 0, 0, 8'h00, 0, 4'h0, 2'd0);
        add(0, 4'hF, 4'hF, DF, 1, 4'h1, 1, 1, 8'h11, 1, 4'h1, 2'd0);
        add(0, 4'hF, 4'hF, DF, 1, 4'h0, 0, 0, 8'h00, 0, 4'h0, 2'd1);
        add(0, 4'hF, 4'hF, DF, 1, 4'h2, 1, 1, 8'h22, 1, 4'h2, 2'd1);
        add(0, 4'h0, 4'h0, 0,  1, 4'h0, 0, 0, 8'h00, 0, 4'h0, 2'd2);
        // pointer wrap: requester 3 burst, then 1 and 3 together
        add(0, 4'h8, 4'h8, 32'h99000000, 1, 4'h0, 0, 0, 8'h00, 0, 4'h0, 2'd2);
        add(0, 4'h8, 4'h8, 32'h99000000, 1, 4'h8, 1, 1, 8'h99, 1, 4'h8, 2'd2);
        add(0, 4'hA, 4'hA, 32'h77005500, 1, 4'h0, 0, 0, 8'h00, 0, 4'h0, 2'd0);
        add(0, 4'hA, 4'hA, 32'h77005500, 1, 4'h2, 1, 1, 8'h55, 1, 4'h2, 2'd0);
        add(0, 4'h0, 4'h0, 0,            1, 4'h0, 0, 0, 8'h00, 0, 4'h0, 2'd2);
        // backpressure on requester 1's four-beat burst
        add(0, 4'h2, 4'h0, 32'h0000A100, 1, 4'h0, 0, 0, 8'h00, 0, 4'h0, 2'd2);
        add(0, 4'h2, 4'h0, 32'h0000A100, 1, 4'h2, 1, 1, 8'hA1, 0, 4'h2, 2'd2);
        add(0, 4'h2, 4'h0, 32'h0000A200, 0, 4'h2, 1, 1, 8'hA2, 0, 4'h0, 2'd2);
        add(0, 4'h2, 4'h0, 32'h0000A200, 0, 4'h2, 1, 1, 8'hA2, 0, 4'h0, 2'd2);
        add(0, 4'h2, 4'h0, 32'h0000A200, 1, 4'h2, 1, 1, 8'hA2, 0, 4'h2, 2'd2);
        add(0, 4'h2, 4'h0, 32'h0000A300, 1, 4'h2, 1, 1, 8'hA3, 0, 4'h2, 2'd2);
        add(0, 4'h2, 4'h2, 32'h0000A400, 1, 4'h2, 1, 1, 8'hA4, 1, 4'h2, 2'd2);
        add(0, 4'h0, 4'h0, 0,            1, 4'h0, 0, 0, 8'h00, 0, 4'h0, 2'd2);

        for (int i = 0; i < tbl.size(); i++) run_vec(tbl[i], i);
        chk("bp_beats", tbl.size(), 32'(bp_beats), 32'd4);

        // reset mid-burst of requester 2, then 0 and 3 request together
        e = '{rst:0, v:4'h4, l:4'h0, d:32'h00BB0000, o:1, g:4'h0, b:0, ov:0, od:8'h00, ol:0, ir:4'h0, p:2'd2};
        run_vec(e, 100);
        e = '{rst:0, v:4'h4, l:4'h0, d:32'h00BB0000, o:1, g:4'h4, b:1, ov:1, od:8'hBB, ol:0, ir:4'h4, p:2'd2};
        run_vec(e, 101);
        e = '{rst:1, v:4'h9, l:4'h9, d:32'hDD0000CC, o:1, g:4'h4, b:1, ov:0, od:8'h00, ol:0, ir:4'h4, p:2'd2};
        run_vec(e, 102);
        e = '{rst:0, v:4'h9, l:4'h9, d:32'hDD0000CC, o:1, g:4'h0, b:0, ov:0, od:8'h00, ol:0, ir:4'h0, p:2'd0};
        run_vec(e, 103);
        e = '{rst:0, v:4'h9, l:4'h9, d:32'hDD0000CC, o:1, g:4'h1, b:1, ov:1, od:8'hCC, ol:1, ir:4'h1, p:2'd0};
        run_vec(e, 104);
        e = '{rst:0, v:4'h0, l:4'h0, d:32'h0, o:1, g:4'h0, b:0, ov:0, od:8'h00, ol:0, ir:4'h0, p:2'd1};
        run_vec(e, 105);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mux_rr_arbiter.md
# mux_rr_arbiter

Round-robin arbiter and sequencer for an N:1 data multiplexer. N requesters share one output channel through valid/ready handshakes. The arbiter picks one requester, holds the mux select for that requester's whole burst (ending on a `last` beat), and then rotates priority. It sits between producer blocks and a single downstream consumer, and it owns the select line that our combinational multiplexers otherwise take as a plain input.

## Interface
- `N`, 4: number of requesters (2..16).
- `W`, 8: data width per beat.

- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  N  per-requester beat valid.
- `in_data`  in  N*W  flattened data; requester i occupies bits [i*W +: W].
- `in_last`  in  N  per-requester end-of-burst flag, qualified by valid.
- `in_ready`  out  N  per-requester ready. Only the granted bit can be 1.
- `out_valid`  out  1  muxed valid.
- `out_data`  out  W  muxed data.
- `out_last`  out  1  muxed last.
- `out_ready`  in  1  downstream ready.
- `grant`  out  N  registered one-hot grant; all zeros when idle.
- `busy`  out  1  high while in GRANT state.

Clock is `clk`. Reset is `rst`: a single clock, with synchronous active-high reset.

## Operation
- **States:** IDLE and GRANT.
- **IDLE:**
  - `grant` = 0, so `out_valid`, `out_last` and `in_ready` are all 0. `out_data` = 0.
  - If any `in_valid` is high, choose the first index i with `in_valid[i]` high, scanning ptr, ptr+1, … wrapping mod N.
  - Register `grant` = one-hot(i) and go to GRANT.
- **GRANT (g = granted index):**
  - `out_valid` = `in_valid[g]`, `out_data` = `in_data[g]`, `out_last` = `in_last[g]`.
  - `in_ready[g]` = `out_ready`. All other `in_ready` bits are 0.
  - A beat transfers when `out_valid` && `out_ready`.
  - A transfer with `out_last` = 1 moves the block to IDLE: `grant` is cleared and ptr ← (g+1) mod N.
  - A transfer with `out_last` = 0 keeps the grant.
- **Stalls:** If the granted requester deasserts valid mid-burst, the grant is held indefinitely. There is no timeout and no preemption.
- **Ignored requests:** Requests from other requesters during GRANT are ignored. They are evaluated at the next IDLE cycle.
- **Pointer (ptr):**
  - Width is clog2(N).
  - Updates only at burst end.
  - Wraps from N-1 to 0.
- **Reset:** Reset has priority over everything, including a mid-burst state. The block returns to state IDLE, ptr = 0, `grant` = 0 and `busy` = 0. The partially sent burst is abandoned and the arbiter does not flag it.

## Timing
- Arbitration latency: request seen in IDLE at cycle t gives `grant` and `out_valid` at cycle t+1.
- Minimum of one IDLE bubble between consecutive bursts. Peak throughput is a burst of L beats every L+1 cycles.
- `out_*` and `in_ready` are combinational from registered `grant` plus current inputs.
  - `in_ready[g]` has a combinational path from `out_ready`.
  - There is no combinational path from `in_valid` to `grant`.
- Single-beat burst (`last` on first beat) with `out_ready` = 1 gives GRANT for exactly one cycle.
- All state updates occur on the rising edge of `clk` only.

## Structure
- Shared package/header `mux_arb_pkg` holds:
  - state encodings `ST_IDLE` = 1'b0 and `ST_GRANT` = 1'b1;
  - a clog2 function for ptr width.
- Natural sub-module: `mux_onehot`, a parameterised N:1, W-bit one-hot AND-OR mux. It is instantiated for data and used for valid/last. Its output is 0 when select is all zeros.
- Top level contains the state register, ptr register, rotate-priority find-first logic, and grant register.

## Test plan
1. **Reset:** Assert `rst` for 2 cycles with all `in_valid` high. Required: `grant` = 0, `busy` = 0, `out_valid` = 0 and `in_ready` = 0 during reset. After reset release, `grant` = 4'b0001 on the next cycle.
2. **Single requester burst:** Requester 2 sends data 0x11, 0x22, 0x33 (last on 0x33) with `out_ready` = 1. Required: `grant` = 4'b0100 one cycle after valid, three beats appear in order, then `grant` = 0 and ptr = 3.
3. **Fairness:** All 4 requesters hold valid with single-beat bursts (`last` = 1). Required: grant sequence 0, 1, 2, 3, 0, 1, each separated by one IDLE cycle, and no requester is served twice before the others.
4. **Backpressure:** During requester 1's 4-beat burst, hold `out_ready` low for 2 cycles at beat 2. Required: `in_ready[1]` = 0 for those cycles, `out_data` is held stable, and all 4 beats are delivered exactly once.
5. **Pointer wrap:** After a burst from requester 3 (ptr = 0), requesters 1 and 3 request together. Required: `grant` = 4'b0010.
6. **Reset mid-burst:** Assert `rst` mid-burst of requester 2, then release with requesters 0 and 3 valid. Required: `grant` = 4'b0001, confirming ptr was reset to 0.
